// File: rtl/vram_arbiter_pkg.sv
// Shared constants and state/tag types for the framebuffer VRAM arbiter.
package lab3_params;

  localparam int FB_W      = 160;
  localparam int FB_H      = 120;
  localparam int FB_ADDR_W = 15;
  localparam int FB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_ACK  = 2'd1,
    RD_WAIT = 2'd2,
    RD_ACK  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    DISP   = 2'd1,
    CPU_RD = 2'd2
  } mem_tag_t;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has strict fixed-latency priority, CPU uses req/ack.
// Optional build macro VBLANK_ONLY_EN restricts CPU writes to vertical blanking.
module vram_arbiter
  import lab3_params::*;
#(
  parameter int ADDR_W  = FB_ADDR_W,
  parameter int DATA_W  = FB_DATA_W,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               disp_req,
  input  logic [ADDR_W-1:0]  disp_addr,
  output logic [DATA_W-1:0]  disp_rdata,
  output logic               disp_valid,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic               cpu_ack,
  output logic [DATA_W-1:0]  cpu_rdata,
  input  logic               vblank,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [STALL_W-1:0] stall_cnt,
  input  logic               stall_clr
);

  localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

  arb_state_t state_r;
  mem_tag_t   tag1_r;
  mem_tag_t   tag2_r;
  logic       grant_ok_s;
  logic       cpu_issue_s;
  logic       stall_evt_s;

`ifdef VBLANK_ONLY_EN
  // Writes wait for blanking so drawing never tears; reads are always allowed.
  always_comb begin
    if (cpu_we && !vblank) begin
      grant_ok_s = 1'b0;
    end else begin
      grant_ok_s = 1'b1;
    end
  end
`else
  logic unused_vblank_s;
  assign unused_vblank_s = vblank;
  assign grant_ok_s      = 1'b1;
`endif

  // CPU issue decision and stall qualification for the current cycle.
  always_comb begin
    cpu_issue_s = 1'b0;
    stall_evt_s = 1'b0;
    if ((state_r == IDLE) && cpu_req) begin
      cpu_issue_s = !disp_req && grant_ok_s;
      stall_evt_s = !cpu_issue_s;
    end else begin
      cpu_issue_s = 1'b0;
      stall_evt_s = 1'b0;
    end
  end

  // Read data returns straight from the RAM; the tag pipeline says who owns it.
  assign disp_rdata = mem_rdata;
  assign cpu_rdata  = mem_rdata;
  assign disp_valid = (tag2_r == DISP);

  // Issue stage, tag pipeline, CPU handshake FSM and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      tag1_r    <= NONE;
      tag2_r    <= NONE;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      tag2_r  <= tag1_r;
      mem_we  <= 1'b0;
      cpu_ack <= 1'b0;

      if (disp_req) begin
        mem_addr <= disp_addr;
        tag1_r   <= DISP;
      end else if (cpu_issue_s) begin
        mem_addr  <= cpu_addr;
        mem_we    <= cpu_we;
        mem_wdata <= cpu_wdata;
        tag1_r    <= cpu_we ? NONE : CPU_RD;
      end else begin
        tag1_r <= NONE;
      end

      // A write acks while its mem_we is on the RAM; a read acks when its data returns.
      case (state_r)
        IDLE: begin
          if (cpu_issue_s) begin
            state_r <= cpu_we ? WR_ACK : RD_WAIT;
            cpu_ack <= cpu_we;
          end else begin
            state_r <= IDLE;
          end
        end
        WR_ACK:  state_r <= IDLE;
        RD_WAIT: begin
          state_r <= RD_ACK;
          cpu_ack <= 1'b1;
        end
        RD_ACK:  state_r <= IDLE;
        default: state_r <= IDLE;
      endcase

      if (stall_clr) begin
        stall_cnt <= '0;
      end else if (stall_evt_s && (stall_cnt != STALL_MAX)) begin
        stall_cnt <= stall_cnt + STALL_ONE;
      end else begin
        stall_cnt <= stall_cnt;
      end
    end
  end

endmodule
